// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the serializer and the sequence detector bench.
//   ser_state_e : serializer FSM states
//   IDLE_BIT    : default level on x while no bit is being sent
package seq_pkg;
  typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_PARITY} ser_state_e;
  localparam logic IDLE_BIT = 1'b1;
endpackage

// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word handshake in, serial bit out.
//   in_data/in_valid/in_ready : upstream valid/ready word channel
//   x/x_valid                 : serial bit to the detector and its qualifier
//   busy                      : a word is in flight
//   master drives words (upstream), slave is the serializer.
interface seq_bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid, in_ready, x, x_valid, busy;
  modport master(output in_data, in_valid, input in_ready, x, x_valid, busy);
  modport slave(input in_data, in_valid, output in_ready, x, x_valid, busy);
endinterface

// File: rtl/seq_bit_serializer_shift_reg.sv
// ser_shift_reg: loadable shift register with a down-counter marking the last bit.
//   clk, reset (sync, active-low)
//   load_i  : copy data_i in and restart the counter at WIDTH-1 (wins over shift_i)
//   shift_i : advance one bit and decrement the counter, saturating at 0
//   head_o  : bit currently presented; last_o : counter is 0
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             head_o,
  output logic             last_o
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sr_d = load_i ? data_i : shift_i ? (MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]}) : sr_q;
    cnt_d = load_i ? CW'(WIDTH - 1) : (shift_i && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    sr_q <= !reset ? '0 : sr_d;
    cnt_q <= !reset ? '0 : cnt_d;
  end
  assign head_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign last_o = cnt_q == '0;
endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-in/serial-out stage feeding the sequence detector.
//   clk, reset (sync, active-low)
//   bus (slave): in_data/in_valid/in_ready word handshake, x/x_valid serial out, busy
//   Define SEQ_SER_PARITY_EN to append an even-parity bit after each word.
module seq_bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = seq_pkg::IDLE_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_bit_serializer_if.slave  bus
);
  import seq_pkg::*;
  ser_state_e state_q, state_d;
  logic ready, acc, head, last;
`ifdef SEQ_SER_PARITY_EN
  logic par_q;
  // Parity cycle takes over the overlap slot, so readiness moves off the last data bit.
  assign ready = state_q == SER_IDLE || state_q == SER_PARITY;
`else
  assign ready = state_q == SER_IDLE || (state_q == SER_SHIFT && last);
`endif
  // Uses the unmasked ready: while reset is low the state register is forced anyway.
  assign acc = bus.in_valid && ready;
  always_comb begin
    state_d = acc ? SER_SHIFT : (state_q == SER_SHIFT && !last) ? SER_SHIFT : SER_IDLE;
`ifdef SEQ_SER_PARITY_EN
    state_d = (state_q == SER_SHIFT && last) ? SER_PARITY : state_d;
`endif
  end
  ser_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (acc),
    .shift_i (state_q == SER_SHIFT),
    .data_i  (bus.in_data),
    .head_o  (head),
    .last_o  (last)
  );
  always_ff @(posedge clk) begin
    state_q <= !reset ? SER_IDLE : state_d;
`ifdef SEQ_SER_PARITY_EN
    par_q <= !reset ? 1'b0 : acc ? ^bus.in_data : par_q;
`endif
  end
  assign bus.in_ready = reset && ready;
  assign bus.x_valid = reset && state_q != SER_IDLE;
  assign bus.busy = reset && state_q != SER_IDLE;
`ifdef SEQ_SER_PARITY_EN
  assign bus.x = (!reset || state_q == SER_IDLE) ? IDLE_BIT : state_q == SER_PARITY ? par_q : head;
`else
  assign bus.x = (!reset || state_q == SER_IDLE) ? IDLE_BIT : head;
`endif
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: scoreboard bench driving an MSB-first and an LSB-first serializer in lockstep.
module tb_seq_bit_serializer;
  import seq_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  bit done = 1'b0;
  int errors = 0;
  int checks = 0;
  bit qm[$];
  bit ql[$];
  always #5 clk = ~clk;
  seq_bit_serializer_if #(.WIDTH(W)) bm();
  seq_bit_serializer_if #(.WIDTH(W)) bl();
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_BIT)) u_msb (.clk(clk), .reset(reset), .bus(bm));
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_BIT)) u_lsb (.clk(clk), .reset(reset), .bus(bl));
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  // The whole word (plus parity when enabled) becomes a list of future bits.
  task automatic push(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back(d[W-1-i]);
      ql.push_back(d[i]);
    end
`ifdef SEQ_SER_PARITY_EN
    qm.push_back(^d);
    ql.push_back(^d);
`endif
  endtask
  // A word is in flight exactly while its bits remain; readiness whenever at most the final bit remains.
  always @(negedge clk) begin
    if (!done) begin
      chk("msb_x_valid", bm.x_valid, qm.size() != 0);
      chk("msb_busy", bm.busy, qm.size() != 0);
      chk("msb_in_ready", bm.in_ready, reset && qm.size() <= 1);
      if (qm.size() != 0) chk("msb_x", bm.x, qm.pop_front());
      else chk("msb_x_idle", bm.x, IDLE_BIT);
      chk("lsb_x_valid", bl.x_valid, ql.size() != 0);
      chk("lsb_busy", bl.busy, ql.size() != 0);
      chk("lsb_in_ready", bl.in_ready, reset && ql.size() <= 1);
      if (ql.size() != 0) chk("lsb_x", bl.x, ql.pop_front());
      else chk("lsb_x_idle", bl.x, IDLE_BIT);
    end
  end
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r);
    bit acc;
    @(negedge clk);
    #2;
    reset = r;
    bm.in_valid = v;
    bl.in_valid = v;
    bm.in_data = d;
    bl.in_data = d;
    acc = v && r && qm.size() == 0;
    @(posedge clk);
    if (!r) begin
      qm.delete();
      ql.delete();
    end else if (acc) push(d);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, W'($urandom), 1'b1);
  endtask
  initial begin
    bm.in_valid = 1'b0;
    bl.in_valid = 1'b0;
    bm.in_data = '0;
    bl.in_data = '0;
    repeat (3) cyc(1'b0, '0, 1'b0);
    idle(2);
    cyc(1'b1, 8'hA5, 1'b1);
    idle(12);
    cyc(1'b1, 8'hC3, 1'b1);
    repeat (W + 1) cyc(1'b1, 8'h0F, 1'b1);
    idle(22);
    cyc(1'b1, 8'h01, 1'b1);
    idle(12);
    cyc(1'b1, 8'hFF, 1'b1);
    idle(2);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'h3C, 1'b1);
    idle(12);
    cyc(1'b1, 8'h5A, 1'b1);
    repeat (12) cyc(1'b1, W'($urandom), 1'b1);
    idle(12);
    cyc(1'b1, 8'h07, 1'b1);
    idle(12);
    cyc(1'b1, 8'h03, 1'b1);
    idle(12);
    repeat (800) cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 79) != 0);
    idle(14);
    @(negedge clk);
    done = 1'b1;
    checks++;
    if (qm.size() != 0 || ql.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d bits left expected 0", qm.size(), ql.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
